// File: rtl/rssb_result_deser_if.sv
// Parallel word handshake between the RSSB result deserializer and its consumer.
interface rssb_result_deser_if #(
  parameter int W = 8
);
  logic [W-1:0] out_data;
  logic         out_flag;
  logic         out_valid;
  logic         out_ready;

  modport master (output out_data, output out_flag, output out_valid, input out_ready);
  modport slave  (input out_data, input out_flag, input out_valid, output out_ready);
endinterface

// File: rtl/rssb_result_deser.sv
// Deserializes the RSSB core's serial result into borrow-tagged W-bit words behind a FWFT FIFO.
// Build option RSSB_DESER_MSB_FIRST_EN: first sampled bit lands in the word MSB instead of the LSB.
module rssb_result_deser #(
  parameter int W     = 8,
  parameter int DEPTH = 4,
  parameter int CW    = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_bit_stb,
  input  logic                  i_ena,
  input  logic                  i_result,
  input  logic                  i_flag,
  rssb_result_deser_if.master   o_bus,
  output logic [CW-1:0]         o_drop_cnt,
  output logic                  o_abort,
  output logic                  o_busy
);

  localparam int CNTW = $clog2(W);
  localparam int AW   = $clog2(DEPTH);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SHIFT = 1'b1;

  logic [0:0]      r_state;
  logic [CNTW-1:0] r_cnt;
  logic [W-1:0]    r_shift;
  logic [W:0]      r_word_p0;
  logic            r_vld_p0;
  logic [W:0]      r_mem [DEPTH];
  logic [AW:0]     r_wptr;
  logic [AW:0]     r_rptr;
  logic [CW-1:0]   r_drop_cnt;
  logic            r_abort;

  logic [CNTW-1:0] w_pos;
  logic [W-1:0]    w_next_shift;
  logic            w_last;
  logic            w_done;
  logic            w_empty;
  logic            w_full;
  logic            w_pop;
  logic            w_push;
  logic [W:0]      w_head;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (&v) ? v : v + CW'(1);
  endfunction

  function automatic logic [CNTW-1:0] bit_pos(input logic [CNTW-1:0] n);
`ifdef RSSB_DESER_MSB_FIRST_EN
    return CNTW'(W - 1) - n;
`else
    return n;
`endif
  endfunction

  always_comb begin
    w_pos               = bit_pos((r_state == ST_SHIFT) ? r_cnt : '0);
    w_next_shift        = (r_state == ST_SHIFT) ? r_shift : '0;
    w_next_shift[w_pos] = i_result;
  end

  assign w_last  = (r_state == ST_SHIFT) && (r_cnt == CNTW'(W - 1));
  assign w_done  = w_last && i_bit_stb && i_ena;
  assign w_empty = (r_wptr == r_rptr);
  assign w_full  = (r_wptr[AW-1:0] == r_rptr[AW-1:0]) && (r_wptr[AW] != r_rptr[AW]);
  assign w_pop   = !w_empty && o_bus.out_ready;
  // A full FIFO still accepts the word when the head leaves on the same edge.
  assign w_push  = r_vld_p0 && (!w_full || w_pop);
  assign w_head  = r_mem[r_rptr[AW-1:0]];

  // Stage p0: completed word registered; FIFO write one cycle later
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_shift    <= '0;
      r_vld_p0   <= 1'b0;
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_drop_cnt <= '0;
      r_abort    <= 1'b0;
    end else begin
      r_vld_p0 <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (i_bit_stb && i_ena) begin
            r_shift <= w_next_shift;
            r_cnt   <= CNTW'(1);
            r_state <= ST_SHIFT;
          end
        end
        default: begin
          if (!i_ena) begin
            r_abort <= 1'b1;
            r_cnt   <= '0;
            r_state <= ST_IDLE;
          end else if (i_bit_stb) begin
            r_shift <= w_next_shift;
            if (w_last) begin
              r_vld_p0 <= 1'b1;
              r_cnt    <= '0;
              r_state  <= ST_IDLE;
            end else begin
              r_cnt <= r_cnt + CNTW'(1);
            end
          end
        end
      endcase

      if (w_push)
        r_wptr <= r_wptr + (AW+1)'(1);
      else if (r_vld_p0)
        r_drop_cnt <= sat_inc(r_drop_cnt);

      if (w_pop)
        r_rptr <= r_rptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_done)
      r_word_p0 <= {i_flag, w_next_shift};
    if (w_push)
      r_mem[r_wptr[AW-1:0]] <= r_word_p0;
  end

  assign o_bus.out_valid = !w_empty;
  assign o_bus.out_data  = w_empty ? '0 : w_head[W-1:0];
  assign o_bus.out_flag  = w_empty ? 1'b0 : w_head[W];
  assign o_drop_cnt      = r_drop_cnt;
  assign o_abort         = r_abort;
  assign o_busy          = (r_state == ST_SHIFT);

endmodule

// File: tb/tb_rssb_result_deser.sv
// Bench for rssb_result_deser: directed scenarios plus random strobes, checked every cycle against a queue model.
module tb_rssb_result_deser;
  localparam int W     = 8;
  localparam int DEPTH = 4;
  localparam int CW    = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          bit_stb = 1'b0;
  logic          ena = 1'b0;
  logic          result = 1'b0;
  logic          flag = 1'b0;
  logic [CW-1:0] drop_cnt;
  logic          abort;
  logic          busy;

  rssb_result_deser_if #(.W(W)) bus ();

  rssb_result_deser #(.W(W), .DEPTH(DEPTH), .CW(CW)) dut (
    .clk        (clk),
    .rst        (rst),
    .i_bit_stb  (bit_stb),
    .i_ena      (ena),
    .i_result   (result),
    .i_flag     (flag),
    .o_bus      (bus),
    .o_drop_cnt (drop_cnt),
    .o_abort    (abort),
    .o_busy     (busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model: bits of the current frame, one pending completed word, FIFO as a queue.
  bit         m_bits[$];
  logic [W:0] m_q[$];
  bit         m_pend;
  logic [W:0] m_pend_w;
  int         m_drop;
  bit         m_abort;
  bit         m_busy;

  function automatic logic [W-1:0] order(input logic [W-1:0] lsb_word);
    logic [W-1:0] r;
`ifdef RSSB_DESER_MSB_FIRST_EN
    for (int i = 0; i < W; i++) r[W-1-i] = lsb_word[i];
`else
    r = lsb_word;
`endif
    return r;
  endfunction

  task automatic model_edge();
    bit pop;
    logic [W-1:0] w;
    if (!rst) begin
      m_bits.delete(); m_q.delete();
      m_pend = 0; m_drop = 0; m_abort = 0; m_busy = 0;
      return;
    end
    pop = (m_q.size() != 0) && (bus.out_ready === 1'b1);
    if (pop) void'(m_q.pop_front());
    if (m_pend) begin
      if (m_q.size() < DEPTH) m_q.push_back(m_pend_w);
      else if (m_drop < (1 << CW) - 1) m_drop++;
    end
    m_pend = 0;
    if (m_busy && !ena) begin
      m_abort = 1; m_bits.delete(); m_busy = 0;
    end else if (bit_stb && ena) begin
      m_bits.push_back(result);
      m_busy = 1;
      if (m_bits.size() == W) begin
        for (int i = 0; i < W; i++) w[i] = m_bits[i];
        m_pend   = 1;
        m_pend_w = {flag, order(w)};
        m_bits.delete();
        m_busy = 0;
      end
    end
  endtask

  task automatic tick();
    logic [W:0] head;
    model_edge();
    @(posedge clk);
    #1;
    head = (m_q.size() != 0) ? m_q[0] : '0;
    chk("valid", bus.out_valid, (m_q.size() != 0));
    chk("data",  bus.out_data,  head[W-1:0]);
    chk("flag",  bus.out_flag,  head[W]);
    chk("drop",  drop_cnt,      m_drop);
    chk("abort", abort,         m_abort);
    chk("busy",  busy,          m_busy);
  endtask

  task automatic send_word(input logic [W-1:0] w, input logic f);
    ena = 1'b1;
    for (int i = 0; i < W; i++) begin
      bit_stb = 1'b1;
      result  = w[i];
      flag    = (i == W - 1) ? f : 1'($urandom);
      tick();
    end
    bit_stb = 1'b0;
    result  = 1'($urandom);
    flag    = 1'($urandom);
  endtask

  task automatic pop_one();
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
  endtask

  task automatic drain();
    bus.out_ready = 1'b1;
    repeat (DEPTH + 3) tick();
    bus.out_ready = 1'b0;
  endtask

  logic [W-1:0] exp_q[4];

  initial begin
    bus.out_ready = 1'b0;

    rst = 1'b0;
    tick(); tick();
    chk("rst_valid", bus.out_valid, 0);
    chk("rst_data",  bus.out_data,  0);
    chk("rst_drop",  drop_cnt,      0);
    chk("rst_abort", abort,         0);
    chk("rst_busy",  busy,          0);
    rst = 1'b1;
    tick();

    // First frame and output latency
    send_word(8'h09, 1'b1);
    chk("lat_c1", bus.out_valid, 0);
    tick();
    chk("lat_c2", bus.out_valid, 1);
`ifdef RSSB_DESER_MSB_FIRST_EN
    chk("word09", bus.out_data, 8'h90);
`else
    chk("word09", bus.out_data, 8'h09);
`endif
    chk("flag09", bus.out_flag, 1);
    pop_one();
    chk("pop09", bus.out_valid, 0);

    // Back-to-back frames
    send_word(8'hA5, 1'b0);
    send_word(8'h3C, 1'b1);
    tick(); tick();
    chk("b2b_a5", bus.out_data, order(8'hA5));
    pop_one();
    chk("b2b_3c", bus.out_data, order(8'h3C));
    chk("b2b_3cf", bus.out_flag, 1);
    pop_one();
    chk("b2b_empty", bus.out_valid, 0);

    // Overflow, then push-with-pop while full
    for (int k = 0; k < 6; k++) send_word(W'(8'h10 + k), 1'(k));
    tick(); tick();
    chk("ovf_drop", drop_cnt, 2);
    chk("ovf_head", bus.out_data, order(8'h10));
    send_word(8'h17, 1'b1);
    pop_one();
    tick();
    chk("ovf_nodrop", drop_cnt, 2);
    exp_q[0] = 8'h11; exp_q[1] = 8'h12; exp_q[2] = 8'h13; exp_q[3] = 8'h17;
    for (int k = 0; k < 4; k++) begin
      chk("ovf_order", bus.out_data, order(exp_q[k]));
      pop_one();
    end
    chk("ovf_empty", bus.out_valid, 0);

    // Abort mid-word
    ena = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bit_stb = 1'b1; result = 1'($urandom); tick();
    end
    bit_stb = 1'b0;
    chk("abt_busy1", busy, 1);
    ena = 1'b0;
    tick();
    chk("abt_flag", abort, 1);
    chk("abt_busy0", busy, 0);
    tick(); tick();
    chk("abt_nopush", bus.out_valid, 0);
    send_word(8'hFF, 1'b0);
    tick(); tick();
    chk("abt_ff", bus.out_data, 8'hFF);
    drain();

    // Reset mid-operation
    send_word(8'h21, 1'b0);
    send_word(8'h22, 1'b1);
    for (int i = 0; i < 5; i++) begin
      bit_stb = 1'b1; result = 1'b1; tick();
    end
    bit_stb = 1'b0;
    rst = 1'b0;
    tick();
    rst = 1'b1;
    chk("mrst_valid", bus.out_valid, 0);
    chk("mrst_drop",  drop_cnt,      0);
    chk("mrst_abort", abort,         0);
    send_word(8'h5A, 1'b1);
    tick(); tick();
    chk("mrst_word", bus.out_data, order(8'h5A));
    drain();

    // Random traffic
    for (int c = 0; c < 600; c++) begin
      bit_stb       = 1'($urandom);
      ena           = ($urandom_range(0, 31) != 0);
      result        = 1'($urandom);
      flag          = 1'($urandom);
      bus.out_ready = ($urandom_range(0, 2) == 0);
      tick();
    end
    bit_stb = 1'b0;
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/rssb_result_deser.md
Name: rssb_result_deser

Overview:
- Downstream consumer of the bit-serial RSSB core.
- Samples the core's serial `result` bit and `flag` (borrow) once per bit strobe while `ena` is high.
- Assembles W-bit words LSB-first, tags each word with the final borrow, and buffers completed words in a small first-word-fall-through FIFO.
- Words are drained by a parallel consumer through a valid/ready handshake.

Parameters:
- W, 8, bits per assembled word (>=2).
- DEPTH, 4, FIFO entries (power of 2, >=2).
- CW, 8, width of the saturating drop counter.

Ports:
- clk  input  1  single block clock (CPU phase strobes are derived from it upstream).
- rst  input  1  synchronous, active-low reset.
- bit_stb  input  1  one-cycle pulse marking the CPU bit-commit phase; sampling happens only on it.
- ena  input  1  CPU enable; high = frame in progress.
- result  input  1  serial result bit from the CPU.
- flag  input  1  CPU borrow bit for the current bit position.
- out_data  output  W  head-of-FIFO word.
- out_flag  output  1  borrow captured on the word's last bit.
- out_valid  output  1  FIFO not empty.
- out_ready  input  1  consumer accepts head when high with out_valid.
- drop_cnt  output  CW  words lost because the FIFO was full; saturates at all-ones.
- abort  output  1  sticky; set when `ena` falls mid-word; cleared only by reset.
- busy  output  1  high in state SHIFT.

Behaviour:
- Reset (rst==0 at a clk edge), outputs:
  - out_valid=0, out_data=0, out_flag=0, drop_cnt=0, abort=0, busy=0.
- Reset, internal state:
  - FIFO pointers cleared, bit counter=0, shift register=0, state=IDLE.
- Reset mid-frame discards the partial word and all buffered words.
- FSM IDLE:
  - On bit_stb && ena: shift register bit 0 <= result, bit counter <= 1, go to SHIFT.
  - bit_stb with ena=0 is ignored.
- FSM SHIFT, bit_stb && ena:
  - Store result at position = bit counter; counter++.
  - When the counter was W-1: the word is complete. Form {flag, word}, attempt a FIFO push, counter <= 0, go to IDLE.
  - If ena is still high on the next strobe, the next word starts immediately with no gap strobe.
- FSM SHIFT, ena==0 in any cycle:
  - Partial word discarded; abort <= 1; counter <= 0; go to IDLE. No push.
- FSM SHIFT, no bit_stb: hold all state.
- Bits are taken exactly at the bit_stb cycle.
- Values of result/flag at other cycles are don't-care.
- FIFO push:
  - Occurs in the cycle after the completing strobe (registered word).
  - out_valid rises one clk after that push cycle, i.e. 2 clks after the last strobe.
- FIFO pop: out_valid && out_ready; the head advances on the same edge.
- FIFO full with push and pop in the same cycle: both happen; no drop.
- FIFO full with push and no pop:
  - Word discarded; drop_cnt++ unless already all-ones.
  - FIFO contents unchanged.
- Empty FIFO with out_ready=1: no effect; pointers never underflow.
- Pointer wrap: log2(DEPTH)+1-bit pointers with a wrap bit.
  - full = same index, different wrap bit.
  - empty = pointers equal.
- out_data/out_flag are stable while out_valid && !out_ready.
- out_data/out_flag are 0 when empty.

Optional Feature:
- Macro: RSSB_DESER_MSB_FIRST_EN.
- Defined:
  - The first sampled bit lands in out_data[W-1] and subsequent bits fill downward.
  - out_flag is the flag at the last strobe (bit 0).
- Undefined (default):
  - LSB-first, first bit into out_data[0].
- Handshake, FSM, FIFO and counters are identical in both builds.

Test Plan:
- Reset then LSB-first frame, W=8:
  - Stimulus: result 1,0,0,1,0,0,0,0 on 8 strobes, flag=1 on the last strobe.
  - Response: out_valid=1 two clks after the 8th strobe, out_data=8'h09, out_flag=1; pop with out_ready -> out_valid=0.
- Back-to-back frames:
  - Stimulus: 16 consecutive strobes with ena high, data words 8'hA5 then 8'h3C, out_ready=0.
  - Response: two entries, popped in order A5 then 3C.
- Overflow:
  - Stimulus: DEPTH=4, out_ready=0, 6 complete frames.
  - Response: first 4 words retained, drop_cnt=2.
  - Follow-up: one pop plus simultaneous 7th frame completion -> no drop, drop_cnt stays 2.
- Abort:
  - Stimulus: ena low after 3 strobes.
  - Response: abort=1, busy=0, no push.
  - Follow-up: next full frame 8'hFF -> out_data=8'hFF.
- Reset mid-operation:
  - Stimulus: 2 words buffered and 5 bits shifted, then rst=0 for one clk.
  - Response: out_valid=0, drop_cnt=0, abort=0; a subsequent frame is assembled from bit 0.
- MSB-first build:
  - Stimulus: same bits as the first scenario with RSSB_DESER_MSB_FIRST_EN defined.
  - Response: out_data=8'h90.
